// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV64 size codes, FSM states, default depth
// and the size-alignment rule.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam int unsigned LSU_DEPTH = 124;

   typedef enum logic [2:0] {
      IDLE,
      LD_REQ,
      LD_WAIT,
      RMW_REQ,
      RMW_WAIT,
      WR
   } lsu_state_e;

   // Size is carried in funct3[1:0] for both signed and unsigned codes.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] off);
      case (funct3[1:0])
         2'b01:   return off[0];
         2'b10:   return |off[1:0];
         2'b11:   return |off;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane datapath: extracts and extends a load lane, and merges a partial store into a
// full doubleword for read-modify-write.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [2:0]  offset,
   input  logic [63:0] line,
   input  logic [63:0] wdata,
   output logic [63:0] load_data,
   output logic [63:0] merged
);

   logic [5:0]  sh;
   logic [63:0] lane;
   logic [63:0] mask;

   assign sh = {offset, 3'b000};

   always_comb begin
      lane      = line >> sh;
      load_data = lane;
      case (funct3)
         F3_B:    load_data = {{56{lane[7]}}, lane[7:0]};
         F3_H:    load_data = {{48{lane[15]}}, lane[15:0]};
         F3_W:    load_data = {{32{lane[31]}}, lane[31:0]};
         F3_BU:   load_data = {56'd0, lane[7:0]};
         F3_HU:   load_data = {48'd0, lane[15:0]};
         F3_WU:   load_data = {32'd0, lane[31:0]};
         default: load_data = lane;
      endcase
   end

   always_comb begin
      mask = '1;
      case (funct3[1:0])
         2'b00:   mask = 64'h0000_0000_0000_00FF;
         2'b01:   mask = 64'h0000_0000_0000_FFFF;
         2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
         default: mask = '1;
      endcase
      merged = (line & ~(mask << sh)) | ((wdata & mask) << sh);
   end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit: one request at a time against a doubleword memory with a one-cycle
// registered read port; sub-doubleword stores are done as read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_AW = 48,
   parameter int unsigned DEPTH  = LSU_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [63:0]       req_addr,
   input  logic [63:0]       req_wdata,
   output logic              resp_valid,
   output logic [63:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic              resp_fault,
   output logic [MEM_AW-1:0] mem_address,
   output logic [63:0]       mem_write_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [63:0]       mem_read_data
);

   lsu_state_e        state, state_d;
   logic [MEM_AW-1:0] idx;
   logic              accept, illegal, fault, misaligned;
   logic [2:0]        funct3_q, off_q;
   logic [63:0]       wdata_q;
   logic [63:0]       load_data, merged;
   logic              unused_addr_hi;

   assign idx            = req_addr[MEM_AW+2:3];
   assign unused_addr_hi = ^req_addr[63:MEM_AW+3];
   assign req_ready      = (state == IDLE);
   assign accept         = req_valid && req_ready;
   assign illegal        = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
   assign fault          = illegal || (64'(idx) >= 64'(DEPTH));
   assign misaligned     = is_misaligned(req_funct3, req_addr[2:0]);
   assign mem_read       = (state == LD_REQ) || (state == RMW_REQ);
   assign mem_write      = (state == WR);

   lsu_byte_lane u_byte_lane (
      .funct3    (funct3_q),
      .offset    (off_q),
      .line      (mem_read_data),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (accept && !fault && !misaligned) begin
               if (!req_we)                state_d = LD_REQ;
               else if (req_funct3 == F3_D) state_d = WR;
               else                        state_d = RMW_REQ;
            end
         end
         LD_REQ:   state_d = LD_WAIT;
         LD_WAIT:  state_d = IDLE;
         RMW_REQ:  state_d = RMW_WAIT;
         RMW_WAIT: state_d = WR;
         WR:       state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_misaligned <= 1'b0;
         resp_fault      <= 1'b0;
         mem_address     <= '0;
         mem_write_data  <= '0;
         funct3_q        <= '0;
         off_q           <= '0;
         wdata_q         <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (fault || misaligned) begin
                     // Rejected without touching memory; fault outranks misalignment.
                     resp_valid      <= 1'b1;
                     resp_rdata      <= '0;
                     resp_fault      <= fault;
                     resp_misaligned <= !fault;
                  end else begin
                     funct3_q    <= req_funct3;
                     off_q       <= req_addr[2:0];
                     wdata_q     <= req_wdata;
                     mem_address <= idx;
                     if (req_we && (req_funct3 == F3_D)) mem_write_data <= req_wdata;
                  end
               end
            end
            LD_WAIT: begin
               resp_valid      <= 1'b1;
               resp_rdata      <= load_data;
               resp_fault      <= 1'b0;
               resp_misaligned <= 1'b0;
            end
            RMW_WAIT: mem_write_data <= merged;
            WR: begin
               resp_valid      <= 1'b1;
               resp_rdata      <= '0;
               resp_fault      <= 1'b0;
               resp_misaligned <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small registered-read memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_misaligned;
   logic        resp_fault;
   logic [47:0] mem_address;
   logic [63:0] mem_write_data;
   logic        mem_write;
   logic        mem_read;
   logic [63:0] mem_read_data;

   logic [63:0] mem [0:123];
   bit          init_done = 1'b0;
   int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
   logic [47:0] last_rd, last_wr;
   int          nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_funct3      (req_funct3),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_misaligned (resp_misaligned),
      .resp_fault      (resp_fault),
      .mem_address     (mem_address),
      .mem_write_data  (mem_write_data),
      .mem_write       (mem_write),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data)
   );

   // Memory model: preloaded with MEMO[i]=i, read data valid one edge after mem_read.
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 124; i++) mem[i] = 64'(i);
         init_done = 1'b1;
      end
      if (mem_read) begin
         rd_cnt++;
         last_rd = mem_address;
         if (mem_address < 48'd124) mem_read_data <= mem[mem_address[6:0]];
         else                       mem_read_data <= '0;
      end
      if (mem_write) begin
         wr_cnt++;
         last_wr = mem_address;
         if (mem_address < 48'd124) mem[mem_address[6:0]] <= mem_write_data;
      end
      if (mem_read && mem_write) both_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issues one request; lat counts edges after the accept edge until resp_valid is seen.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, output int lat, output logic [63:0] rd,
                         output logic mis, output logic flt);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      // Scramble inputs after accept: the unit must use its latched copy.
      req_valid  = 1'b0;
      req_we     = ~we;
      req_funct3 = ~f3;
      req_addr   = addr ^ 64'h38;
      req_wdata  = ~wd;
      lat = 0;
      while (!resp_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rd  = resp_rdata;
      mis = resp_misaligned;
      flt = resp_fault;
   endtask

   int          lat, r0, w0;
   logic [63:0] rd;
   logic        mis, flt;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_rdata", resp_rdata, 64'd0);
      check("rst_mis", 64'(resp_misaligned), 64'd0);
      check("rst_fault", 64'(resp_fault), 64'd0);
      check("rst_addr", 64'(mem_address), 64'd0);
      check("rst_wdata", mem_write_data, 64'd0);
      check("rst_rd", 64'(mem_read), 64'd0);
      check("rst_wr", 64'(mem_write), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // LD 0x28
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(1'b0, 3'b011, 64'h28, 64'h0, lat, rd, mis, flt);
      check("ld28_lat", 64'(lat), 64'd2);
      check("ld28_data", rd, 64'h5);
      check("ld28_rdcnt", 64'(rd_cnt - r0), 64'd1);
      check("ld28_idx", 64'(last_rd), 64'd5);

      // SB 0x11 <- 0x80
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(1'b1, 3'b000, 64'h11, 64'h1234_5678_9ABC_DE80, lat, rd, mis, flt);
      check("sb_lat", 64'(lat), 64'd3);
      check("sb_rdcnt", 64'(rd_cnt - r0), 64'd1);
      check("sb_wrcnt", 64'(wr_cnt - w0), 64'd1);
      check("sb_idx", 64'(last_wr), 64'd2);
      check("sb_mem", mem[2], 64'h0000_0000_0000_8002);
      check("sb_rdata", rd, 64'd0);
      do_req(1'b0, 3'b000, 64'h11, 64'h0, lat, rd, mis, flt);
      check("lb_data", rd, 64'hFFFF_FFFF_FFFF_FF80);
      do_req(1'b0, 3'b100, 64'h11, 64'h0, lat, rd, mis, flt);
      check("lbu_data", rd, 64'h80);
      do_req(1'b0, 3'b001, 64'h10, 64'h0, lat, rd, mis, flt);
      check("lh_data", rd, 64'hFFFF_FFFF_FFFF_8002);
      do_req(1'b0, 3'b101, 64'h10, 64'h0, lat, rd, mis, flt);
      check("lhu_data", rd, 64'h8002);

      // SH 0x22 then word loads of the merged doubleword
      do_req(1'b1, 3'b001, 64'h22, 64'h1234_ABCD, lat, rd, mis, flt);
      check("sh_mem", mem[4], 64'h0000_0000_ABCD_0004);
      do_req(1'b0, 3'b010, 64'h20, 64'h0, lat, rd, mis, flt);
      check("lw_data", rd, 64'hFFFF_FFFF_ABCD_0004);
      do_req(1'b0, 3'b110, 64'h20, 64'h0, lat, rd, mis, flt);
      check("lwu_data", rd, 64'h0000_0000_ABCD_0004);

      // Misaligned LW 0x0A
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(1'b0, 3'b010, 64'h0A, 64'h0, lat, rd, mis, flt);
      check("mis_lat", 64'(lat), 64'd0);
      check("mis_flag", 64'(mis), 64'd1);
      check("mis_fault", 64'(flt), 64'd0);
      check("mis_rdata", rd, 64'd0);
      check("mis_strobes", 64'(rd_cnt - r0 + wr_cnt - w0), 64'd0);

      // Faults: index 124, illegal store funct3
      do_req(1'b0, 3'b011, 64'h3E0, 64'h0, lat, rd, mis, flt);
      check("oor_fault", 64'(flt), 64'd1);
      check("oor_lat", 64'(lat), 64'd0);
      do_req(1'b1, 3'b100, 64'h8, 64'hFF, lat, rd, mis, flt);
      check("st100_fault", 64'(flt), 64'd1);
      check("st100_mis", 64'(mis), 64'd0);
      // Misaligned and out of range together: fault wins
      do_req(1'b0, 3'b011, 64'h3E4, 64'h0, lat, rd, mis, flt);
      check("prio_fault", 64'(flt), 64'd1);
      check("fault_strobes", 64'(rd_cnt - r0 + wr_cnt - w0), 64'd0);

      // SW 0x18 with reset pulsed in RMW_WAIT
      w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 64'h18; req_wdata = 64'hAAAA_5555;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rmwrst_ready", 64'(req_ready), 64'd1);
      check("rmwrst_wr", 64'(mem_write), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rmwrst_wrcnt", 64'(wr_cnt - w0), 64'd0);
      check("rmwrst_mem", mem[3], 64'd3);

      // SD accepted in the response cycle of a load, then read back
      do_req(1'b0, 3'b011, 64'h28, 64'h0, lat, rd, mis, flt);
      check("b2b_resp", 64'(resp_valid), 64'd1);
      check("b2b_ready", 64'(req_ready), 64'd1);
      w0 = wr_cnt;
      do_req(1'b1, 3'b011, 64'h30, 64'hDEAD_BEEF_0000_0001, lat, rd, mis, flt);
      check("sd_lat", 64'(lat), 64'd1);
      check("sd_wrcnt", 64'(wr_cnt - w0), 64'd1);
      check("sd_mem", mem[6], 64'hDEAD_BEEF_0000_0001);
      do_req(1'b0, 3'b011, 64'h30, 64'h0, lat, rd, mis, flt);
      check("ld30_data", rd, 64'hDEAD_BEEF_0000_0001);

      check("never_both", 64'(both_cnt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_AW, default 48, width of the doubleword index driven to data memory.
REQ-002 Parameter DEPTH, default 124, number of 64-bit memory entries; index >= DEPTH is out of range.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV64 size code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-009 req_addr  input  64  byte address.
REQ-010 req_wdata  input  64  store data; the low size bytes are used.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  64  extended load result; 0 for stores and faults.
REQ-013 resp_misaligned  output  1  valid with resp_valid; address not size-aligned.
REQ-014 resp_fault  output  1  valid with resp_valid; illegal funct3 (load 111, store 1xx) or index >= DEPTH.
REQ-015 mem_address  output  MEM_AW  doubleword index = req_addr[MEM_AW+2:3], registered at accept.
REQ-016 mem_write_data  output  64  registered write doubleword.
REQ-017 mem_write, mem_read  output  1 each  memory strobes, decoded from state only.
REQ-018 mem_read_data  input  64  memory read port; valid one edge after the edge sampling mem_read=1.

Function
REQ-019 States SHALL be IDLE, LD_REQ, LD_WAIT, RMW_REQ, RMW_WAIT, WR.
REQ-020 mem_read SHALL be 1 exactly in LD_REQ and RMW_REQ; mem_write SHALL be 1 exactly in WR; never both.
REQ-021 Accept check order SHALL be: fault, then misaligned; on either, no state change and no memory strobe; next cycle resp_valid=1 with the flag set (fault has priority over misaligned).
REQ-022 Load: IDLE->LD_REQ->LD_WAIT->IDLE; in LD_WAIT extract little-endian lane at offset req_addr[2:0] and sign- or zero-extend per funct3; resp_valid and resp_rdata are registered, so they appear 2 cycles after the accept edge.
REQ-023 SD: IDLE->WR->IDLE, mem_write_data=req_wdata; resp_valid 1 cycle after the accept edge.
REQ-024 SB/SH/SW: IDLE->RMW_REQ->RMW_WAIT->WR->IDLE; RMW_WAIT merges the low size bytes of the request into mem_read_data at the byte offset, other bytes preserved; resp_valid 3 cycles after the accept edge.
REQ-025 Alignment rule: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0; B is always aligned.
REQ-026 Request fields (we, funct3, offset, wdata) SHALL be latched at accept; input changes after accept have no effect.
REQ-027 resp_valid SHALL be high for exactly one cycle per accepted request; a new request may be accepted in the same cycle resp_valid is high.
REQ-028 req_valid while not IDLE SHALL be ignored and not queued.

Reset
REQ-029 rst SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_rdata=0, both flags 0, mem_address=0, mem_write_data=0, mem_read=0, mem_write=0.
REQ-030 rst during any RMW state SHALL abandon the access with no memory write issued; the memory contents stay unchanged.

Structure
REQ-031 Shared package lsu_pkg SHALL hold the funct3 size encodings, the state enum, and the default DEPTH.
REQ-032 One combinational sub-module lsu_byte_lane SHALL perform load extraction and extension, plus store merge.

Verification (memory preloaded with MEMO[i]=i)
REQ-033 LD addr 0x28 -> mem_read for 1 cycle, mem_address=5, resp_valid at accept+2, resp_rdata=0x5.
REQ-034 SB addr 0x11 data 0x80 -> read then write of index 2 = 0x0000_0000_0000_8002, resp at accept+3; then LB 0x11 -> 0xFFFF_FFFF_FFFF_FF80; LBU 0x11 -> 0x80.
REQ-035 LW addr 0x0A -> resp_misaligned=1, resp_rdata=0 at accept+1, no mem_read or mem_write ever asserted.
REQ-036 LD addr 0x3E0 (index 124) -> resp_fault=1; store funct3=100 -> resp_fault=1; no memory strobes.
REQ-037 SW addr 0x18 (index 3), rst pulsed in RMW_WAIT -> mem_write never asserted, MEMO[3]=3, req_ready=1 during reset.
REQ-038 SD 0x30 data 0xDEAD_BEEF_0000_0001 accepted in the resp_valid cycle of a prior load -> WR next cycle, then LD 0x30 returns the same value.
